cpa_share_arb: RTL

//  Shares one combinational carry-propagate adder (CPA, e.g. a prefix-tree adder such as MG_CPA)

---
 rtl/cpa_share_arb_if.sv | 28 ++
 rtl/cpa_share_arb.sv | 92 +++++++++
 2 files changed

// File: rtl/cpa_share_arb_if.sv
// cpa_share_arb_if: requester, result and CPA-side signals of the shared-adder arbiter
interface cpa_share_arb_if #(
    parameter int WIDTH = 7,
    parameter int NREQ  = 2,
    parameter int ID_W  = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [WIDTH-1:0]      cpa_a;
    logic [WIDTH-1:0]      cpa_b;
    logic [WIDTH-1:0]      cpa_sum;
    logic                  cpa_cout;
    logic                  res_valid;
    logic                  res_ready;
    logic [WIDTH-1:0]      res_sum;
    logic                  res_cout;
    logic [ID_W-1:0]       res_id;
    modport slave (
        input  req_valid, req_a, req_b, cpa_sum, cpa_cout, res_ready,
        output req_ready, cpa_a, cpa_b, res_valid, res_sum, res_cout, res_id
    );
    modport master (
        output req_valid, req_a, req_b, cpa_sum, cpa_cout, res_ready,
        input  req_ready, cpa_a, cpa_b, res_valid, res_sum, res_cout, res_id
    );
endinterface

// File: rtl/cpa_share_arb.sv
// cpa_share_arb: round-robin sharing of one external CPA, operand reg -> CPA -> result reg
module cpa_share_arb #(
    parameter int WIDTH = 7,
    parameter int NREQ  = 2,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cpa_share_arb_if.slave       bus,
    output logic [15:0]          op_count
);
    logic             s1_v_q, s1_v_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [ID_W-1:0]  s1_id_q, s1_id_d;
    logic [ID_W-1:0]  rr_q, rr_d;
    logic             res_v_q, res_v_d;
    logic [WIDTH-1:0] res_sum_q, res_sum_d;
    logic             res_cout_q, res_cout_d;
    logic [ID_W-1:0]  res_id_q, res_id_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             found;
    logic [ID_W-1:0]  g;
    logic             s2_ready, s1_ready, accept, adv, hs;

    assign s2_ready = !res_v_q || bus.res_ready;
    assign s1_ready = !s1_v_q || s2_ready;
    assign accept   = found && s1_ready;
    assign adv      = s1_v_q && s2_ready;
    assign hs       = res_v_q && bus.res_ready;

    assign bus.req_ready = accept ? NREQ'(1) << g : '0;
    assign bus.cpa_a     = s1_a_q;
    assign bus.cpa_b     = s1_b_q;
    assign bus.res_valid = res_v_q;
    assign bus.res_sum   = res_sum_q;
    assign bus.res_cout  = res_cout_q;
    assign bus.res_id    = res_id_q;
    assign op_count      = cnt_q;

    // first valid requester at or after the round-robin pointer, wrapping modulo NREQ
    always_comb begin
        found = 1'b0;
        g     = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && bus.req_valid[(int'(rr_q) + k) % NREQ]) begin
                found = 1'b1;
                g     = ID_W'((int'(rr_q) + k) % NREQ);
            end
        end
    end

    // next state of both pipeline stages, the pointer and the handshake counter
    always_comb begin
        s1_v_d     = accept || (s1_v_q && !s2_ready);
        s1_a_d     = accept ? bus.req_a[int'(g)*WIDTH +: WIDTH] : s1_a_q;
        s1_b_d     = accept ? bus.req_b[int'(g)*WIDTH +: WIDTH] : s1_b_q;
        s1_id_d    = accept ? g : s1_id_q;
        rr_d       = accept ? ((int'(g) == NREQ-1) ? '0 : g + 1'b1) : rr_q;
        res_v_d    = adv || (res_v_q && !bus.res_ready);
        res_sum_d  = adv ? bus.cpa_sum : res_sum_q;
        res_cout_d = adv ? bus.cpa_cout : res_cout_q;
        res_id_d   = adv ? s1_id_q : res_id_q;
        cnt_d      = hs ? cnt_q + 16'd1 : cnt_q;
    end

    // state registers; reset discards anything in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_q     <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
            rr_q       <= '0;
            res_v_q    <= 1'b0;
            res_sum_q  <= '0;
            res_cout_q <= 1'b0;
            res_id_q   <= '0;
            cnt_q      <= '0;
        end else begin
            s1_v_q     <= s1_v_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_id_q    <= s1_id_d;
            rr_q       <= rr_d;
            res_v_q    <= res_v_d;
            res_sum_q  <= res_sum_d;
            res_cout_q <= res_cout_d;
            res_id_q   <= res_id_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule
